// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between two requesters:
//   port 0 - pipeline MEM stage
//   port 1 - debug/DMA loader
// Each port uses a req/ack handshake. When both ports request together, a
// round-robin pointer picks the winner. The winner's command is latched. The
// memory strobes are then held for LATENCY cycles. Read data is registered
// into the winner's rdata register, and a one-cycle ack is returned.
//
// Optional build macro: DMEM_ARB_ALIGN_CHECK_EN
//   When defined, a granted access whose addr[1:0] != 0 never reaches the
//   memory. The arbiter returns ack together with a one-cycle err_o pulse.
//   When undefined, err_o is tied low and addresses pass through unmodified.
//
// Parameters
//   LATENCY : cycles the memory strobes are held before read data is sampled (>=1)
//   AW      : address width
//   DW      : data width
//
// Ports
//   clk_i, rst_i                  : clock (rising edge), async active-low reset
//   mN_req_i / mN_we_i            : request, write(1)/read(0), port N = 0,1
//   mN_addr_i / mN_wdata_i        : byte address and write data, port N
//   mN_ack_o / mN_rdata_o         : completion pulse, read data (valid with ack)
//   mem_we_o / mem_re_o           : memory MemWrite / MemRead strobes
//   mem_addr_o / mem_wdata_o      : memory Addr / WriteData
//   mem_rdata_i                   : memory ReadData
//   busy_o                        : high whenever the FSM is not IDLE
//   err_o                         : misaligned-access pulse (optional feature)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int LATENCY = 1,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic          m0_ack_o,
    output logic [DW-1:0] m0_rdata_o,

    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_ack_o,
    output logic [DW-1:0] m1_rdata_o,

    output logic          mem_we_o,
    output logic          mem_re_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,

    output logic          busy_o,
    output logic          err_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    // The counter only has to hold LATENCY-1.
    localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    logic [1:0]    state;
    logic          rr_ptr;    // port favoured on the next simultaneous request
    logic          gnt_id;    // port currently being served
    logic [CW-1:0] count;

    // Winner selection for the current IDLE cycle
    logic          req_any;
    logic          sel;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    always_comb begin
        req_any   = m0_req_i | m1_req_i;
        // rr_ptr matters only when both ports ask. Otherwise the lone requester wins.
        sel       = (m0_req_i && m1_req_i) ? rr_ptr : m1_req_i;
        sel_we    = sel ? m1_we_i    : m0_we_i;
        sel_addr  = sel ? m1_addr_i  : m0_addr_i;
        sel_wdata = sel ? m1_wdata_i : m0_wdata_i;
    end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic misalign;
    logic err_q;

    assign misalign = (sel_addr[1:0] != 2'b00);
    assign err_o    = err_q;
`else
    assign err_o    = 1'b0;
`endif

    assign busy_o = (state != IDLE);

    // The mem_* output registers double as the latched command. The inputs
    // may change after the grant without disturbing the access in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            gnt_id      <= 1'b0;
            count       <= '0;
            mem_we_o    <= 1'b0;
            mem_re_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            m0_ack_o    <= 1'b0;
            m1_ack_o    <= 1'b0;
            m0_rdata_o  <= '0;
            m1_rdata_o  <= '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            // Acks (and err) are single-cycle pulses and default low.
            m0_ack_o <= 1'b0;
            m1_ack_o <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            err_q    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_any) begin
                        gnt_id <= sel;
                        rr_ptr <= ~sel;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                        if (misalign) begin
                            // Reject without touching memory: ack and err go out together.
                            state <= DONE;
                            err_q <= 1'b1;
                            if (sel) m1_ack_o <= 1'b1;
                            else     m0_ack_o <= 1'b1;
                        end else
`endif
                        begin
                            state       <= ACCESS;
                            count       <= CNT_INIT;
                            mem_we_o    <= sel_we;
                            mem_re_o    <= ~sel_we;
                            mem_addr_o  <= sel_addr;
                            mem_wdata_o <= sel_wdata;
                        end
                    end
                end

                ACCESS: begin
                    if (count == '0) begin
                        state    <= DONE;
                        mem_we_o <= 1'b0;
                        mem_re_o <= 1'b0;
                        // The last strobe cycle is the read-data sample point.
                        if (mem_re_o) begin
                            if (gnt_id) m1_rdata_o <= mem_rdata_i;
                            else        m0_rdata_o <= mem_rdata_i;
                        end
                        if (gnt_id) m1_ack_o <= 1'b1;
                        else        m0_ack_o <= 1'b1;
                    end else begin
                        count <= count - 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
